spk_layer_sequencer: RTL and testbench

//  Top-level phase sequencer for one inference: waits for layer-1 (encoder) weight load, runs the

---
 rtl/spk_layer_sequencer.sv | 141 ++++++++++++++
 tb/tb_spk_layer_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spk_layer_sequencer.sv
// Phase sequencer for one inference: encoder weight load, encoder run,
// then weight load and run for each downstream PE-array layer.
module spk_layer_sequencer #(
    parameter int          NUM_LAYERS = 4,
    parameter int          IDX_W      = 4,
    parameter int          BEAT_W     = 16,
    parameter int          TO_W       = 20,
    parameter int unsigned TIMEOUT    = 20'hFFFFF
) (
    input  logic              s_clk,
    input  logic              s_rst,
    input  logic              i_start,
    input  logic              i_enc_w_load_done,
    input  logic              i_enc_out_done,
    input  logic              i_w_beat,
    input  logic [BEAT_W-1:0] i_layer_w_beats,
    input  logic              i_pe_layer_done,
    output logic              o_weight_load_done,
    output logic              o_pe_start,
    output logic [IDX_W-1:0]  o_layer_idx,
    output logic              o_network_cal_done,
    output logic              o_busy,
    output logic              o_error,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ENC_WLOAD = 3'd1,
        S_ENC_RUN   = 3'd2,
        S_PE_WLOAD  = 3'd3,
        S_PE_RUN    = 3'd4,
        S_NEXT      = 3'd5,
        S_DONE      = 3'd6,
        S_ERR       = 3'd7
    } state_t;

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LAYERS - 1);

    state_t              r_state;
    state_t              w_next;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic [TO_W-1:0]     r_wd_cnt;
    logic [IDX_W-1:0]    r_layer_idx;
    logic                r_wld;
    logic                r_pes;
    logic                r_cal;
    logic                r_err;

    logic                w_waiting;
    logic                w_timeout;
    logic [BEAT_W:0]     w_beat_inc;
    logic                w_wload_hit;
    logic                w_last_layer;
    logic                w_wload_fire;

    assign w_waiting = (r_state == S_ENC_WLOAD) || (r_state == S_ENC_RUN) ||
                       (r_state == S_PE_WLOAD)  || (r_state == S_PE_RUN);

    assign w_timeout = (TIMEOUT != 0) && w_waiting && (r_wd_cnt == TO_LAST);

    // One extra bit so a saturated counter can never alias a beat target
    assign w_beat_inc  = {1'b0, r_beat_cnt} + 1'b1;
    assign w_wload_hit = (i_layer_w_beats == '0) ||
                         (i_w_beat && (w_beat_inc == {1'b0, i_layer_w_beats}));

    assign w_last_layer = (r_layer_idx == IDX_LAST);
    assign w_wload_fire = (r_state == S_PE_WLOAD) && (w_next == S_PE_RUN);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:      if (i_start) w_next = S_ENC_WLOAD;
            S_ENC_WLOAD: if (i_enc_w_load_done) w_next = S_ENC_RUN;
            S_ENC_RUN:   if (i_enc_out_done) w_next = S_PE_WLOAD;
            S_PE_WLOAD:  if (w_wload_hit) w_next = S_PE_RUN;
            S_PE_RUN:    if (i_pe_layer_done) w_next = S_NEXT;
            S_NEXT:      w_next = w_last_layer ? S_DONE : S_PE_WLOAD;
            S_DONE:      w_next = S_IDLE;
            S_ERR:       w_next = S_ERR;
            default:     w_next = S_IDLE;
        endcase
        // A stalled wait state loses to the watchdog even if its event arrives
        if (w_timeout) begin
            w_next = S_ERR;
        end
    end

    always_ff @(posedge s_clk) begin
        if (s_rst) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_wd_cnt    <= '0;
            r_layer_idx <= '0;
            r_wld       <= 1'b0;
            r_pes       <= 1'b0;
            r_cal       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;

            if ((w_next != r_state) || !w_waiting) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
            end

            if ((r_state != S_PE_WLOAD) || (w_next != S_PE_WLOAD)) begin
                r_beat_cnt <= '0;
            end else if (i_w_beat && !(&r_beat_cnt)) begin
                r_beat_cnt <= r_beat_cnt + 1'b1;
            end

            if ((r_state == S_ENC_RUN) && (w_next == S_PE_WLOAD)) begin
                r_layer_idx <= '0;
            end else if ((r_state == S_NEXT) && (w_next == S_PE_WLOAD)) begin
                r_layer_idx <= r_layer_idx + 1'b1;
            end else if (r_state == S_DONE) begin
                r_layer_idx <= '0;
            end

            r_wld <= w_wload_fire;
            r_pes <= w_wload_fire;
            r_cal <= (w_next == S_DONE);

            if (w_next == S_ERR) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_weight_load_done = r_wld;
    assign o_pe_start         = r_pes;
    assign o_layer_idx        = r_layer_idx;
    assign o_network_cal_done = r_cal;
    assign o_busy             = (r_state != S_IDLE) && (r_state != S_ERR);
    assign o_error            = r_err;
    assign o_state            = r_state;

endmodule

// File: tb/tb_spk_layer_sequencer.sv
// Bench for spk_layer_sequencer: directed scenarios plus random traffic,
// every cycle checked against a phase-level reference model.
module tb_spk_layer_sequencer;

    localparam int NL = 2;
    localparam int IW = 4;
    localparam int BW = 16;
    localparam int TW = 20;
    localparam int TO = 64;

    logic          s_clk = 1'b0;
    logic          s_rst;
    logic          i_start;
    logic          i_enc_w_load_done;
    logic          i_enc_out_done;
    logic          i_w_beat;
    logic [BW-1:0] i_layer_w_beats;
    logic          i_pe_layer_done;
    logic          o_weight_load_done;
    logic          o_pe_start;
    logic [IW-1:0] o_layer_idx;
    logic          o_network_cal_done;
    logic          o_busy;
    logic          o_error;
    logic [2:0]    o_state;

    always #5 s_clk = ~s_clk;

    spk_layer_sequencer #(
        .NUM_LAYERS(NL), .IDX_W(IW), .BEAT_W(BW), .TO_W(TW), .TIMEOUT(TO)
    ) dut (
        .s_clk(s_clk), .s_rst(s_rst), .i_start(i_start),
        .i_enc_w_load_done(i_enc_w_load_done),
        .i_enc_out_done(i_enc_out_done), .i_w_beat(i_w_beat),
        .i_layer_w_beats(i_layer_w_beats),
        .i_pe_layer_done(i_pe_layer_done),
        .o_weight_load_done(o_weight_load_done), .o_pe_start(o_pe_start),
        .o_layer_idx(o_layer_idx), .o_network_cal_done(o_network_cal_done),
        .o_busy(o_busy), .o_error(o_error), .o_state(o_state)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: phase, layer, beats seen, cycles spent waiting
    int m_st, m_idx, m_beat, m_wd;
    bit m_err, m_wld, m_pes, m_cal;

    int cc = 0;
    int bcnt = 0;
    int ncal = 0;
    int err_cc = -1;
    int wld_q[$], pes_q[$], pesidx_q[$], beat_q[$], went_q[$];

    int k_beats = 3;
    int k_pld = 4;
    bit k_alt = 0;
    bit k_stray = 0;
    bit k_go = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, got, exp, cc);
        end
    endtask

    task automatic model_step();
        int nst;
        bit hit;
        if (s_rst) begin
            m_st = 0; m_idx = 0; m_beat = 0; m_wd = 0;
            m_err = 0; m_wld = 0; m_pes = 0; m_cal = 0;
            return;
        end
        hit = (i_layer_w_beats == 0) ||
              (i_w_beat && (m_beat + 1 == int'(i_layer_w_beats)));
        nst = m_st;
        case (m_st)
            0: if (i_start) nst = 1;
            1: if (i_enc_w_load_done) nst = 2;
            2: if (i_enc_out_done) nst = 3;
            3: if (hit) nst = 4;
            4: if (i_pe_layer_done) nst = 5;
            5: nst = (m_idx == NL - 1) ? 6 : 3;
            6: nst = 0;
            default: nst = 7;
        endcase
        if (m_st >= 1 && m_st <= 4 && m_wd == TO - 1) nst = 7;
        m_wld = (m_st == 3) && (nst == 4);
        m_pes = m_wld;
        m_cal = (nst == 6);
        if (nst == 7) m_err = 1;
        if (m_st == 2 && nst == 3) m_idx = 0;
        else if (m_st == 5 && nst == 3) m_idx = m_idx + 1;
        else if (m_st == 6) m_idx = 0;
        if (m_st != 3 || nst != 3) m_beat = 0;
        else if (i_w_beat && m_beat < 65535) m_beat = m_beat + 1;
        m_wd = (nst == m_st && m_st >= 1 && m_st <= 4) ? m_wd + 1 : 0;
        m_st = nst;
    endtask

    task automatic cyc();
        if (!s_rst && m_st == 3 && m_wd == 0) went_q.push_back(cc);
        if (!s_rst && m_st == 3) begin
            if (i_w_beat) begin
                bcnt++;
                if (bcnt == int'(i_layer_w_beats)) beat_q.push_back(cc);
            end
        end else begin
            bcnt = 0;
        end
        model_step();
        @(posedge s_clk);
        #1;
        cc++;
        chk("state", o_state, m_st);
        chk("layer_idx", o_layer_idx, m_idx);
        chk("busy", o_busy, (m_st != 0 && m_st != 7) ? 1 : 0);
        chk("error", o_error, m_err);
        chk("weight_load_done", o_weight_load_done, m_wld);
        chk("pe_start", o_pe_start, m_pes);
        chk("network_cal_done", o_network_cal_done, m_cal);
        if (o_weight_load_done) wld_q.push_back(cc);
        if (o_pe_start) begin
            pes_q.push_back(cc);
            pesidx_q.push_back(int'(o_layer_idx));
        end
        if (o_network_cal_done) ncal++;
        if (o_error && err_cc < 0) err_cc = cc;
    endtask

    task automatic clr_log();
        wld_q.delete(); pes_q.delete(); pesidx_q.delete();
        beat_q.delete(); went_q.delete();
        ncal = 0;
    endtask

    task automatic zero_in();
        i_start = 0; i_enc_w_load_done = 0; i_enc_out_done = 0;
        i_w_beat = 0; i_pe_layer_done = 0;
    endtask

    task automatic auto_in();
        s_rst = 0;
        i_start = k_go && (m_st == 0);
        i_enc_w_load_done = (m_st == 1);
        i_enc_out_done = (m_st == 2) && (m_wd == 2);
        i_layer_w_beats = BW'(k_beats);
        i_w_beat = (m_st == 3 && (!k_alt || (cc % 2 == 0))) ||
                   (m_st == 4 && k_stray);
        i_pe_layer_done = (m_st == 4) && (m_wd == k_pld);
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        do begin
            auto_in();
            cyc();
            if (m_st != 0) k_go = 0;
            n++;
        end while ((m_st != 0 || k_go) && n < maxc);
        chk("run_idle_end", o_state, 0);
    endtask

    task automatic run_to(input int st, input int idx, input int maxc);
        int n = 0;
        do begin
            auto_in();
            cyc();
            if (m_st != 0) k_go = 0;
            n++;
        end while (!(m_st == st && m_idx == idx) && n < maxc);
        chk("run_to_state", o_state, st);
    endtask

    initial begin
        s_rst = 1;
        zero_in();
        i_layer_w_beats = '0;
        model_step();
        repeat (2) cyc();
        chk("rst_state", o_state, 0);
        chk("rst_busy", o_busy, 0);

        // Nominal run with a fixed timeline
        clr_log();
        for (int c = 0; c < 80; c++) begin
            s_rst = 0;
            i_start = (c == 0);
            i_enc_w_load_done = (c >= 5);
            i_enc_out_done = (c == 20);
            i_layer_w_beats = 16'd3;
            i_w_beat = (m_st == 3);
            i_pe_layer_done = (m_st == 4) && (m_wd == 10);
            cyc();
        end
        chk("nom_pe_starts", pes_q.size(), 2);
        if (pesidx_q.size() == 2) begin
            chk("nom_idx0", pesidx_q[0], 0);
            chk("nom_idx1", pesidx_q[1], 1);
        end
        chk("nom_cal_pulses", ncal, 1);
        chk("nom_end_state", o_state, 0);
        chk("nom_end_busy", o_busy, 0);

        // Beat counting, sparse beats, stray beats during PE_RUN
        clr_log();
        zero_in();
        k_beats = 5; k_alt = 1; k_stray = 1; k_pld = 3; k_go = 1;
        run_idle(300);
        chk("beat_wld_count", wld_q.size(), 2);
        if (wld_q.size() == 2 && beat_q.size() >= 2) begin
            chk("beat_l0_latency", wld_q[0] - beat_q[0], 1);
            chk("beat_l1_latency", wld_q[1] - beat_q[1], 1);
        end

        // Zero-beat layers
        clr_log();
        k_beats = 0; k_alt = 0; k_stray = 0; k_go = 1;
        run_idle(300);
        chk("zero_wld_count", wld_q.size(), 2);
        if (wld_q.size() >= 1 && pes_q.size() >= 1 && went_q.size() >= 1) begin
            chk("zero_wld_latency", wld_q[0] - went_q[0], 1);
            chk("zero_pes_latency", pes_q[0] - went_q[0], 1);
        end

        // Ignored start and pe_done during encoder run
        clr_log();
        k_beats = 2; k_go = 1;
        run_to(2, 0, 50);
        i_start = 1; i_pe_layer_done = 1; i_enc_out_done = 0;
        cyc();
        chk("ign_state", o_state, 2);
        chk("ign_pe_start", o_pe_start, 0);
        run_idle(300);
        chk("ign_pe_starts", pes_q.size(), 2);

        // Watchdog on a withheld pe_done
        clr_log();
        err_cc = -1;
        k_pld = -1; k_go = 1;
        run_to(7, 0, 300);
        if (pes_q.size() >= 1) chk("wd_latency", err_cc - pes_q[0], 64);
        chk("wd_error", o_error, 1);
        zero_in();
        i_start = 1;
        cyc();
        zero_in();
        cyc();
        chk("wd_start_ignored", o_state, 7);
        chk("wd_busy", o_busy, 0);
        s_rst = 1;
        cyc();
        s_rst = 0;

        // Reset in the middle of layer 1 weight load
        clr_log();
        k_pld = 4; k_beats = 6; k_alt = 1; k_go = 1;
        run_to(3, 1, 300);
        s_rst = 1;
        zero_in();
        cyc();
        chk("mid_rst_state", o_state, 0);
        chk("mid_rst_idx", o_layer_idx, 0);
        chk("mid_rst_busy", o_busy, 0);
        clr_log();
        k_go = 1; k_beats = 1; k_alt = 0;
        run_idle(300);
        chk("mid_rst_rerun_starts", pes_q.size(), 2);
        chk("mid_rst_rerun_cal", ncal, 1);

        // Random traffic, last segment starves pe_done to hit the watchdog
        for (int seg = 0; seg < 4; seg++) begin
            for (int n = 0; n < 800; n++) begin
                s_rst = ((m_st == 7) && ($urandom % 8 == 0)) ||
                        ($urandom % 300 == 0);
                i_start = ($urandom % 4 == 0);
                i_enc_w_load_done = ($urandom % 3 == 0);
                i_enc_out_done = ($urandom % 6 == 0);
                i_w_beat = ($urandom % 2 == 0);
                i_layer_w_beats = BW'($urandom_range(0, 4));
                i_pe_layer_done = (seg == 3) ? ($urandom % 500 == 0)
                                             : ($urandom % 6 == 0);
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
